psum_row_reducer: RTL and testbench

//  Parametrised row-reduction stage behind the psum memory: takes one psum row (COL signed
//  BW_PSUM-bit lanes) per handshake and produces its cross-column sum, signed or sum-of-|x|.

---
 rtl/psum_row_reducer.sv | 109 ++++++++++
 tb/tb_psum_row_reducer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_row_reducer.sv
// psum_row_reducer: 2-stage pipelined signed / sum-of-|x| row reduction with per-frame max tracking
module psum_row_reducer #(
  parameter int COL = 8,
  parameter int BW_PSUM = 20,
  parameter int ADDR_W = 4,
  parameter int FRAME_LEN = 16,
  localparam int SUM_W = BW_PSUM + $clog2(COL) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COL*BW_PSUM-1:0] in_data,
  input  logic [ADDR_W-1:0]      in_tag,
  input  logic                   in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SUM_W-1:0]       sum_out,
  output logic [ADDR_W-1:0]      out_tag,
  output logic                   frame_done,
  output logic [SUM_W-1:0]       frame_max,
  output logic [ADDR_W-1:0]      frame_max_tag
);
  localparam int CNT_W = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  logic                     en, hs, last, take;
  logic                     s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [ADDR_W-1:0]        s1_tag_q, s1_tag_d, out_tag_q, out_tag_d;
  logic signed [SUM_W-1:0]  s1_lane_q [COL];
  logic signed [SUM_W-1:0]  s1_lane_d [COL];
  logic signed [SUM_W-1:0]  ext, acc, sum_q, sum_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [SUM_W-1:0]  run_max_q, run_max_d, new_max;
  logic [ADDR_W-1:0]        run_tag_q, run_tag_d, new_tag;
  logic                     frame_done_q, frame_done_d;
  logic signed [SUM_W-1:0]  frame_max_q, frame_max_d;
  logic [ADDR_W-1:0]        frame_tag_q, frame_tag_d;

  // Pipeline: both stages advance together whenever the output slot is free or being taken
  always_comb begin
    en = ~s2_valid_q | out_ready;
    in_ready = reset & en & ~clear;
    s1_valid_d = clear ? 1'b0 : en ? in_valid & in_ready : s1_valid_q;
    s1_tag_d = en ? in_tag : s1_tag_q;
    ext = '0;
    for (int c = 0; c < COL; c++) begin
      ext = {{(SUM_W-BW_PSUM){in_data[c*BW_PSUM+BW_PSUM-1]}}, in_data[c*BW_PSUM +: BW_PSUM]};
      s1_lane_d[c] = ~en ? s1_lane_q[c] : in_mode & ext[SUM_W-1] ? -ext : ext;
    end
    acc = '0;
    for (int c = 0; c < COL; c++) acc = acc + s1_lane_q[c];
    s2_valid_d = clear ? 1'b0 : en ? s1_valid_q : s2_valid_q;
    sum_d = en ? acc : sum_q;
    out_tag_d = en ? s1_tag_q : out_tag_q;
  end

  // Frame statistics: running max per output handshake, published on the last row of a frame
  always_comb begin
    hs = s2_valid_q & out_ready & ~clear;
    last = cnt_q == CNT_W'(FRAME_LEN - 1);
    take = cnt_q == '0 || sum_q > run_max_q;
    new_max = take ? sum_q : run_max_q;
    new_tag = take ? out_tag_q : run_tag_q;
    cnt_d = clear ? '0 : ~hs ? cnt_q : last ? '0 : cnt_q + CNT_W'(1);
    run_max_d = clear ? '0 : hs ? new_max : run_max_q;
    run_tag_d = clear ? '0 : hs ? new_tag : run_tag_q;
    frame_done_d = hs & last;
    frame_max_d = clear ? '0 : hs & last ? new_max : frame_max_q;
    frame_tag_d = clear ? '0 : hs & last ? new_tag : frame_tag_q;
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_tag_q <= '0;
      for (int c = 0; c < COL; c++) s1_lane_q[c] <= '0;
      s2_valid_q <= 1'b0;
      sum_q <= '0;
      out_tag_q <= '0;
      cnt_q <= '0;
      run_max_q <= '0;
      run_tag_q <= '0;
      frame_done_q <= 1'b0;
      frame_max_q <= '0;
      frame_tag_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tag_q <= s1_tag_d;
      s1_lane_q <= s1_lane_d;
      s2_valid_q <= s2_valid_d;
      sum_q <= sum_d;
      out_tag_q <= out_tag_d;
      cnt_q <= cnt_d;
      run_max_q <= run_max_d;
      run_tag_q <= run_tag_d;
      frame_done_q <= frame_done_d;
      frame_max_q <= frame_max_d;
      frame_tag_q <= frame_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign sum_out = sum_q;
  assign out_tag = out_tag_q;
  assign frame_done = frame_done_q;
  assign frame_max = frame_max_q;
  assign frame_max_tag = frame_tag_q;
endmodule

// File: tb/tb_psum_row_reducer.sv
// tb_psum_row_reducer: vector table, directed corner sequences and random traffic against a queue model
module tb_psum_row_reducer;
  localparam int COL = 8, BW = 20, AW = 4, FL = 4, SW = 24;
  logic clk = 0, reset = 0, clear = 0, in_valid = 0, in_mode = 0, out_ready = 0;
  logic [COL*BW-1:0] in_data = '0;
  logic [AW-1:0] in_tag = '0;
  logic in_ready, out_valid, frame_done;
  logic [SW-1:0] sum_out, frame_max;
  logic [AW-1:0] out_tag, frame_max_tag;

  psum_row_reducer #(.COL(COL), .BW_PSUM(BW), .ADDR_W(AW), .FRAME_LEN(FL)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .sum_out(sum_out), .out_tag(out_tag), .frame_done(frame_done),
    .frame_max(frame_max), .frame_max_tag(frame_max_tag));

  always #5 clk = ~clk;

  typedef struct {longint sum; logic [AW-1:0] tag;} exp_t;
  typedef struct {logic [COL*BW-1:0] data; logic mode; logic [AW-1:0] tag; longint sum;} vec_t;
  exp_t q[$];
  int n_chk = 0, n_err = 0, done_seen = 0, popped = 0, m_cnt = 0;
  logic drv_valid = 0, drv_mode = 0, drv_oready = 0, drv_clear = 0, accepted = 0, exp_done = 0;
  logic [COL*BW-1:0] drv_data = '0;
  logic [AW-1:0] drv_tag = '0, exp_ftag = '0, m_tag = '0;
  longint exp_fmax = 0, m_max = 0;

  task automatic chk(string name, longint act, longint want);
    n_chk++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic flag(string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: condition not met", name);
  endtask

  function automatic longint ref_sum(logic [COL*BW-1:0] d, logic m);
    longint s = 0;
    for (int c = 0; c < COL; c++) begin
      longint v = longint'($signed(d[c*BW +: BW]));
      if (m && v < 0) v = -v;
      s += v;
    end
    return s;
  endfunction

  function automatic logic [COL*BW-1:0] mk(longint base, longint step);
    logic [COL*BW-1:0] d;
    for (int c = 0; c < COL; c++) d[c*BW +: BW] = BW'(base + c * step);
    return d;
  endfunction

  function automatic logic [COL*BW-1:0] one(longint v);
    logic [COL*BW-1:0] d = '0;
    d[BW-1:0] = BW'(v);
    return d;
  endfunction

  function automatic logic [COL*BW-1:0] rnd_data();
    logic [COL*BW-1:0] d;
    for (int c = 0; c < COL; c++) begin
      int r = $urandom_range(0, 9);
      d[c*BW +: BW] = r == 0 ? 20'h80000 : r == 1 ? 20'h7FFFF : 20'($urandom);
    end
    return d;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cnt = 0; m_max = 0; m_tag = '0;
    exp_done = 0; exp_fmax = 0; exp_ftag = '0;
  endtask

  // One clock: check registered outputs, apply staged inputs, then advance the model
  task automatic tick();
    logic ohs;
    exp_t e;
    @(negedge clk);
    chk("frame_done", frame_done, exp_done);
    chk("frame_max", $signed(frame_max), exp_fmax);
    chk("frame_max_tag", frame_max_tag, exp_ftag);
    if (frame_done) done_seen++;
    if (out_valid) begin
      if (q.size() == 0) flag("spurious_out_valid");
      else begin
        chk("sum_out", $signed(sum_out), q[0].sum);
        chk("out_tag", out_tag, q[0].tag);
      end
    end
    in_valid = drv_valid; in_data = drv_data; in_mode = drv_mode; in_tag = drv_tag;
    clear = drv_clear; out_ready = drv_oready;
    #1;
    chk("in_ready_rule", in_ready, (!out_valid || out_ready) && !clear);
    accepted = in_valid && in_ready;
    ohs = out_valid && out_ready && !clear;
    exp_done = 0;
    if (clear) model_reset();
    else begin
      if (ohs && q.size() > 0) begin
        e = q.pop_front();
        popped++;
        if (m_cnt == 0 || e.sum > m_max) begin m_max = e.sum; m_tag = e.tag; end
        m_cnt++;
        if (m_cnt == FL) begin exp_done = 1; exp_fmax = m_max; exp_ftag = m_tag; m_cnt = 0; end
      end
      if (accepted) begin
        e.sum = ref_sum(in_data, in_mode);
        e.tag = in_tag;
        q.push_back(e);
      end
    end
  endtask

  task automatic send(logic [COL*BW-1:0] d, logic m, logic [AW-1:0] t);
    drv_valid = 1; drv_data = d; drv_mode = m; drv_tag = t;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) flag("send_timeout");
    drv_valid = 0;
  endtask

  task automatic drain();
    drv_valid = 0; drv_oready = 1;
    for (int i = 0; i < 30; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drain_left", q.size(), 0);
    tick();
    tick();
  endtask

  task automatic do_clear();
    drv_clear = 1;
    tick();
    drv_clear = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int d0, p0;
    tbl[0] = '{mk(1, 1), 1'b0, 4'd3, 36};
    tbl[1] = '{mk(-5, 0), 1'b1, 4'd1, 40};
    tbl[2] = '{mk(-5, 0), 1'b0, 4'd2, -40};
    tbl[3] = '{mk(-524288, 0), 1'b1, 4'd4, 4194304};
    tbl[4] = '{mk(-524288, 0), 1'b0, 4'd5, -4194304};
    tbl[5] = '{mk(-3, 1), 1'b1, 4'd6, 16};
    tbl[6] = '{mk(-3, 1), 1'b0, 4'd7, 4};
    tbl[7] = '{mk(524287, 0), 1'b0, 4'd8, 4194296};
    tbl[8] = '{mk(524287, 0), 1'b1, 4'd9, 4194296};

    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum_out", sum_out, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_max", frame_max, 0);
    chk("rst_frame_max_tag", frame_max_tag, 0);
    #9 reset = 1;

    drv_oready = 1;
    foreach (tbl[i]) begin
      drv_valid = 1; drv_data = tbl[i].data; drv_mode = tbl[i].mode; drv_tag = tbl[i].tag;
      tick();
      chk("tbl_accept", accepted, 1);
      drv_valid = 0;
      @(posedge clk); #2;
      chk("tbl_lat_early", out_valid, 0);
      tick();
      @(posedge clk); #2;
      chk("tbl_lat_valid", out_valid, 1);
      chk("tbl_sum", $signed(sum_out), tbl[i].sum);
      chk("tbl_tag", out_tag, tbl[i].tag);
      tick();
    end
    drain();

    do_clear();
    drv_oready = 0;
    send(mk(10, 1), 0, 4'd1);
    send(mk(-7, 0), 1, 4'd2);
    drv_valid = 1; drv_data = mk(3, -2); drv_mode = 0; drv_tag = 4'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    p0 = popped;
    drv_oready = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) flag("stall_release_timeout");
    drain();
    chk("stall_results", popped - p0, 3);

    do_clear();
    d0 = done_seen;
    send(one(5), 0, 4'd1);
    send(one(9), 0, 4'd2);
    send(one(9), 0, 4'd5);
    send(one(2), 0, 4'd6);
    drain();
    chk("frame_done_pulses", done_seen - d0, 1);
    chk("frame_max_tie", $signed(frame_max), 9);
    chk("frame_max_tag_tie", frame_max_tag, 2);

    send(one(100), 0, 4'd1);
    send(one(50), 0, 4'd2);
    drain();
    drv_oready = 0;
    send(one(11), 0, 4'd7);
    send(one(12), 0, 4'd8);
    drv_oready = 1;
    do_clear();
    @(posedge clk); #2;
    chk("clear_frame_max", $signed(frame_max), 0);
    chk("clear_frame_tag", frame_max_tag, 0);
    chk("clear_out_valid", out_valid, 0);
    d0 = done_seen;
    for (int i = 1; i <= 4; i++) send(one(i), 0, AW'(i));
    drain();
    chk("clear_frame_done", done_seen - d0, 1);
    chk("clear_frame_max_new", $signed(frame_max), 4);
    chk("clear_frame_tag_new", frame_max_tag, 4);

    drv_oready = 0;
    send(one(7), 0, 4'd3);
    send(one(8), 1, 4'd4);
    #2;
    reset = 0;
    in_valid = 0; drv_valid = 0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_sum_out", sum_out, 0);
    chk("arst_out_tag", out_tag, 0);
    chk("arst_frame_max", frame_max, 0);
    chk("arst_frame_tag", frame_max_tag, 0);
    model_reset();
    @(negedge clk); #3;
    reset = 1;
    drv_oready = 1;
    for (int i = 0; i < 4; i++) tick();

    for (int i = 0; i < 600; i++) begin
      if (!drv_valid || accepted) begin
        drv_valid = $urandom_range(0, 9) < 7;
        drv_data = rnd_data();
        drv_mode = 1'($urandom);
        drv_tag = 4'($urandom);
      end
      drv_oready = $urandom_range(0, 9) < 7;
      drv_clear = $urandom_range(0, 49) == 0;
      tick();
    end
    drv_clear = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
